// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: pipeline writeback, multi-cycle results,
// read-address snooping and the shared register-file write port.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_wr_en;
    logic [4:0]    pipe_wr_addr;
    logic [31:0]   pipe_wr_data;
    logic          div_valid;
    logic [4:0]    div_addr;
    logic [31:0]   div_data;
    logic          div_ready;
    logic [4:0]    rd_addr1;
    logic [4:0]    rd_addr2;
    logic          pend_hit1;
    logic          pend_hit2;
    logic          rf_wr_en;
    logic [4:0]    rf_wr_addr;
    logic [31:0]   rf_wr_data;
    logic          grant_src;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    // Arbiter side.
    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  div_valid, div_addr, div_data,
        input  rd_addr1, rd_addr2,
        output div_ready, pend_hit1, pend_hit2,
        output rf_wr_en, rf_wr_addr, rf_wr_data, grant_src,
        output stall_req, fifo_count
    );

    // Pipeline / result-source side.
    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output div_valid, div_addr, div_data,
        output rd_addr1, rd_addr2,
        input  div_ready, pend_hit1, pend_hit2,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, grant_src,
        input  stall_req, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results queue in a small FIFO, get squashed by younger pipeline writes, and
// raise stall_req when starved.

// One FIFO slot: valid/addr/data plus read-address and squash matching.
module wb_arbiter_entry (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_i,
    input  logic        clr_i,
    input  logic        sq_en_i,
    input  logic [4:0]  sq_addr_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [4:0]  rd_addr1_i,
    input  logic [4:0]  rd_addr2_i,
    output logic        vld_o,
    output logic [4:0]  addr_o,
    output logic [31:0] data_o,
    output logic        hit1_o,
    output logic        hit2_o
);
    logic        vld_q, vld_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    // A write into this slot wins over a same-cycle squash: the new result
    // was produced after the pipeline write it would otherwise match.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clr_i || (sq_en_i && (addr_q == sq_addr_i))) vld_d = 1'b0;
        if (wr_i) begin
            vld_d  = 1'b1;
            addr_d = wr_addr_i;
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign hit1_o = vld_q && (addr_q == rd_addr1_i);
    assign hit2_o = vld_q && (addr_q == rd_addr2_i);
endmodule

module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    logic [DEPTH-1:0]       ent_vld, ent_hit1, ent_hit2, ent_wr, ent_clr;
    logic [DEPTH-1:0][4:0]  ent_addr;
    logic [DEPTH-1:0][31:0] ent_data;

    logic div_ready, push, pop, pipe_req, nonempty, head_vld, fifo_grant;

    // Reset gating keeps every port quiet while reset is held, even though
    // some of these terms are combinational from the inputs.
    assign div_ready  = reset && (cnt_q < DEPTH_C);
    assign push       = bus.div_valid && div_ready && (bus.div_addr != 5'd0);
    assign pipe_req   = reset && bus.pipe_wr_en && (bus.pipe_wr_addr != 5'd0);
    assign nonempty   = (cnt_q != '0);
    assign head_vld   = nonempty && ent_vld[rptr_q];
    assign fifo_grant = head_vld && !pipe_req;
    // Squashed heads drain unconditionally so they never block live entries.
    assign pop        = nonempty && (fifo_grant || !ent_vld[rptr_q]);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_wr[g]  = push && (wptr_q == PW'(g));
        assign ent_clr[g] = pop && (rptr_q == PW'(g));

        wb_arbiter_entry u_ent (
            .clk       (clk),
            .reset     (reset),
            .wr_i      (ent_wr[g]),
            .clr_i     (ent_clr[g]),
            .sq_en_i   (pipe_req),
            .sq_addr_i (bus.pipe_wr_addr),
            .wr_addr_i (bus.div_addr),
            .wr_data_i (bus.div_data),
            .rd_addr1_i(bus.rd_addr1),
            .rd_addr2_i(bus.rd_addr2),
            .vld_o     (ent_vld[g]),
            .addr_o    (ent_addr[g]),
            .data_o    (ent_data[g]),
            .hit1_o    (ent_hit1[g]),
            .hit2_o    (ent_hit2[g])
        );
    end

    always_comb begin
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Starvation: only a live head blocked by the pipeline counts.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (fifo_grant || !head_vld) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else begin
            if (starve_q != LIMIT_C) starve_d = starve_q + SW'(1);
            if (starve_d == LIMIT_C) stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_addr = 5'd0;
        bus.rf_wr_data = 32'd0;
        bus.grant_src  = 1'b0;
        if (pipe_req) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_wr_addr = bus.pipe_wr_addr;
            bus.rf_wr_data = bus.pipe_wr_data;
        end else if (fifo_grant) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_wr_addr = ent_addr[rptr_q];
            bus.rf_wr_data = ent_data[rptr_q];
            bus.grant_src  = 1'b1;
        end
    end

    assign bus.pend_hit1  = reset && (bus.rd_addr1 != 5'd0) &&
                            ((|ent_hit1) || (push && (bus.div_addr == bus.rd_addr1)));
    assign bus.pend_hit2  = reset && (bus.rd_addr2 != 5'd0) &&
                            ((|ent_hit2) || (push && (bus.div_addr == bus.rd_addr2)));
    assign bus.div_ready  = div_ready;
    assign bus.stall_req  = stall_q;
    assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter (DEPTH=4, STARVE_LIMIT=8) with a
// per-cycle expected-output scoreboard and a hand-written reset-mid-burst case.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(4)) bus ();
    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic pe; logic [4:0] pa; logic [31:0] pd;
        logic dv; logic [4:0] da; logic [31:0] dd;
        logic [4:0] r1; logic [4:0] r2;
        logic en; logic [4:0] wa; logic [31:0] wd; logic src;
        logic rdy; logic [2:0] cnt; logic h1; logic h2; logic st;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   id_q[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   bad_wr = 0;

    function automatic vec_t mk(
        input logic pe, input logic [4:0] pa, input logic [31:0] pd,
        input logic dv, input logic [4:0] da, input logic [31:0] dd,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic src,
        input logic rdy, input logic [2:0] cnt, input logic h1, input logic h2, input logic st);
        vec_t v;
        v.pe = pe; v.pa = pa; v.pd = pd; v.dv = dv; v.da = da; v.dd = dd;
        v.r1 = r1; v.r2 = r2; v.en = en; v.wa = wa; v.wd = wd; v.src = src;
        v.rdy = rdy; v.cnt = cnt; v.h1 = h1; v.h2 = h2; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.pipe_wr_en = v.pe; bus.pipe_wr_addr = v.pa; bus.pipe_wr_data = v.pd;
        bus.div_valid = v.dv; bus.div_addr = v.da; bus.div_data = v.dd;
        bus.rd_addr1 = v.r1; bus.rd_addr2 = v.r2;
    endtask

    task automatic idle();
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
    endtask

    // Scoreboard: pop the expectation pushed by the driver for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            chk("rf_wr_en",   id, 32'(bus.rf_wr_en),   32'(e.en));
            chk("rf_wr_addr", id, 32'(bus.rf_wr_addr), 32'(e.wa));
            chk("rf_wr_data", id, bus.rf_wr_data,      e.wd);
            if (e.en) chk("grant_src", id, 32'(bus.grant_src), 32'(e.src));
            chk("div_ready",  id, 32'(bus.div_ready),  32'(e.rdy));
            chk("fifo_count", id, 32'(bus.fifo_count), 32'(e.cnt));
            chk("pend_hit1",  id, 32'(bus.pend_hit1),  32'(e.h1));
            chk("pend_hit2",  id, 32'(bus.pend_hit2),  32'(e.h2));
            chk("stall_req",  id, 32'(bus.stall_req),  32'(e.st));
        end
    end

    // Writes that must never reach the register file.
    always @(negedge clk) begin
        if (reset && bus.rf_wr_en) begin
            if (bus.rf_wr_addr == 5'd0) bad_wr++;
            if (bus.rf_wr_addr == 5'd9 && bus.rf_wr_data == 32'hAA) bad_wr++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_after;
        // pe,pa,pd, dv,da,dd, r1,r2, en,wa,wd,src, rdy,cnt,h1,h2,st
        vecs.push_back(mk(0,0,0,       1,7,'h22,  7,7,  0,0,0,0,        1,0,1,1,0));
        vecs.push_back(mk(1,5,'h11,    0,0,0,     7,7,  1,5,'h11,0,     1,1,1,1,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     7,0,  1,7,'h22,1,     1,1,1,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     7,0,  0,0,0,0,        1,0,0,0,0));
        vecs.push_back(mk(0,0,0,       1,3,'h33,  0,3,  0,0,0,0,        1,0,0,1,0));
        vecs.push_back(mk(1,0,'hFFFF,  1,0,'h44,  3,0,  1,3,'h33,1,     1,1,1,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     3,0,  0,0,0,0,        1,0,0,0,0));
        vecs.push_back(mk(1,1,'h101,   1,10,'hA0, 0,0,  1,1,'h101,0,    1,0,0,0,0));
        vecs.push_back(mk(1,1,'h102,   1,11,'hA1, 10,0, 1,1,'h102,0,    1,1,1,0,0));
        vecs.push_back(mk(1,1,'h103,   1,12,'hA2, 0,0,  1,1,'h103,0,    1,2,0,0,0));
        vecs.push_back(mk(1,1,'h104,   1,13,'hA3, 0,13, 1,1,'h104,0,    1,3,0,1,0));
        vecs.push_back(mk(1,1,'h105,   1,14,'hA4, 0,14, 1,1,'h105,0,    0,4,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  1,10,'hA0,1,    0,4,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  1,11,'hA1,1,    1,3,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  1,12,'hA2,1,    1,2,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  1,13,'hA3,1,    1,1,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  0,0,0,0,        1,0,0,0,0));
        vecs.push_back(mk(0,0,0,       1,9,'hAA,  9,0,  0,0,0,0,        1,0,1,0,0));
        vecs.push_back(mk(1,9,'hBB,    0,0,0,     9,0,  1,9,'hBB,0,     1,1,1,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     9,0,  0,0,0,0,        1,1,0,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     9,0,  0,0,0,0,        1,0,0,0,0));
        vecs.push_back(mk(1,6,'h61,    1,6,'h66,  6,0,  1,6,'h61,0,     1,0,1,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     6,0,  1,6,'h66,1,     1,1,1,0,0));
        vecs.push_back(mk(0,0,0,       0,0,0,     6,0,  0,0,0,0,        1,0,0,0,0));
        vecs.push_back(mk(1,2,'h200,   1,8,'h88,  0,0,  1,2,'h200,0,    1,0,0,0,0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1,2,32'h200+k, 0,0,0, 0,0, 1,2,32'h200+k,0, 1,1,0,0,0));
        vecs.push_back(mk(1,2,'h2FF,   0,0,0,     0,0,  1,2,'h2FF,0,    1,1,0,0,1));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  1,8,'h88,1,     1,1,0,0,1));
        vecs.push_back(mk(0,0,0,       0,0,0,     0,0,  0,0,0,0,        1,0,0,0,0));

        // Outputs held quiet in reset even with live requests on the inputs.
        drive(mk(1,5,1, 1,3,'h33, 3,3, 0,0,0,0, 0,0,0,0,0));
        #2;
        chk("rst_rf_wr_en",   -1, 32'(bus.rf_wr_en),   0);
        chk("rst_div_ready",  -1, 32'(bus.div_ready),  0);
        chk("rst_fifo_count", -1, 32'(bus.fifo_count), 0);
        chk("rst_pend_hit1",  -1, 32'(bus.pend_hit1),  0);
        chk("rst_grant_src",  -1, 32'(bus.grant_src),  0);
        chk("rst_stall_req",  -1, 32'(bus.stall_req),  0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle();

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            id_q.push_back(i);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);

        // Reset mid-burst: three buffered results, then reset while pipe writes.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(mk(1,4,32'h400+k, 1,5'd20+5'(k),32'h500+k, 0,0, 0,0,0,0, 0,0,0,0,0));
        end
        @(posedge clk); #1;
        drive(mk(1,4,'h4FF, 0,0,0, 20,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        chk("burst_fifo_count", -2, 32'(bus.fifo_count), 3);
        chk("burst_pend_hit1",  -2, 32'(bus.pend_hit1),  1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_fifo_count", -2, 32'(bus.fifo_count), 0);
        chk("mid_rst_rf_wr_en",   -2, 32'(bus.rf_wr_en),   0);
        chk("mid_rst_div_ready",  -2, 32'(bus.div_ready),  0);
        chk("mid_rst_pend_hit1",  -2, 32'(bus.pend_hit1),  0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle();
        wr_after = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rf_wr_en) wr_after++;
        end
        chk("post_rst_writes",     -2, 32'(wr_after),       0);
        chk("post_rst_fifo_count", -2, 32'(bus.fifo_count), 0);
        chk("post_rst_div_ready",  -2, 32'(bus.div_ready),  1);
        chk("forbidden_writes",    -3, 32'(bad_wr),         0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-port arbiter in front of the register file. It shares the single register-file write port between the in-order pipeline writeback and a multi-cycle result source, such as the divider. Multi-cycle results wait in a small FIFO. The block also flags pending reads of buffered destinations and requests a pipeline stall when the buffered results are starved of the write port.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive starved cycles before stall_req is raised; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_wr_en  in  1  pipeline writeback request; has no backpressure.
- pipe_wr_addr  in  5  pipeline destination register.
- pipe_wr_data  in  32  pipeline result.
- div_valid  in  1  multi-cycle result valid.
- div_addr  in  5  multi-cycle destination register.
- div_data  in  32  multi-cycle result.
- div_ready  out  1  FIFO can accept a result.
- rd_addr1, rd_addr2  in  5 each  register-file read addresses currently being issued.
- pend_hit1, pend_hit2  out  1 each  the read address has a pending buffered write.
- rf_wr_en  out  1  to register-file wr_en.
- rf_wr_addr  out  5  to register-file wr_addr.
- rf_wr_data  out  32  to register-file wr_data.
- grant_src  out  1  0 = pipeline, 1 = FIFO; meaningful only while rf_wr_en = 1.
- stall_req  out  1  registered request for the pipeline to idle its writeback.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries, valid or squashed.

## Operation
- **FIFO entry format:** {valid, addr[4:0], data[31:0]}; circular read/write pointers plus a count.
- **div_ready:** equals (fifo_count < DEPTH); derived from registered state only.
- **Accept:** a result is accepted when div_valid && div_ready.
  - An accepted result with div_addr = 0 is discarded and not enqueued.
  - There is no bypass: an accepted result always enters the FIFO.
- **Pipeline writes to $0:** pipe_wr_en with pipe_wr_addr = 0 is treated as no request. The register file forwards wr_data even for $0, so the arbiter never drives rf_wr_en with rf_wr_addr = 0.
- **Grant (combinational, priority order):**
  1. Pipeline request with nonzero address: rf_* = pipe_*, grant_src = 0.
  2. Otherwise, a valid head entry: rf_* = head, grant_src = 1, head is popped.
  3. Otherwise: rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0.
- **Squashed head:** a head entry with valid = 0 pops every cycle regardless of grant, and never drives rf_wr_en.
- **Squash rule:** a granted pipeline write clears valid on every stored entry whose addr matches pipe_wr_addr. The pipeline write is architecturally younger.
  - A result accepted in the same cycle with the same address is still enqueued valid.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **pend_hit:** pend_hitN = (rd_addrN != 0) && (any valid stored entry matches, or an accepted nonzero div_addr matches this cycle).
- **Starvation counter:**
  - Increments in each cycle where the head is valid and the pipeline holds the port.
  - Clears on a FIFO grant, or when no valid head exists.
  - Saturates at STARVE_LIMIT.
- **stall_req:**
  - Sets at the edge at which the counter reaches STARVE_LIMIT.
  - Clears at the edge following the first FIFO grant, or when no valid head remains.
- **stall_req contract:** the pipeline keeps pipe_wr_en = 0 while stall_req = 1. If the pipeline violates this, it still wins the port, no data is lost, and stall_req stays high.
- **Reset (reset = 0, asynchronous):**
  - Clears pointers, count, valid bits, counter and stall_req.
  - While reset = 0: div_ready = 0, rf_wr_en = 0, pend_hit* = 0, grant_src = 0, fifo_count = 0.
  - Results in flight during reset are lost.

## Timing
- Pipeline path: zero latency; rf_wr_* follows pipe_* in the same cycle, and the register file writes at the next edge.
- FIFO path: minimum one cycle from the accept edge to rf_wr_en with grant_src = 1.
- Throughput: one register-file write per cycle. A FIFO entry waits only while the pipeline holds the port.
- div_ready drops the cycle after the FIFO fills. It rises the cycle after a pop from full.
- stall_req first asserts STARVE_LIMIT cycles after starvation begins. It deasserts one cycle after the starved entry is granted.

## Test plan
- **Reset mid-burst:** DEPTH=4. Accept 3 results, then pull reset low while the pipeline is writing -> fifo_count = 0 and rf_wr_en = 0 immediately; after release, no stale entry is ever written.
- **Priority:** pipe writes r5 = 0x11 while the FIFO head is r7 = 0x22 -> cycle 1: rf = (r5, 0x11, src 0); cycle 2 with pipe idle: rf = (r7, 0x22, src 1).
- **$0 filtering:** pipe writes r0 = 0xFFFF with a valid head entry -> head granted the same cycle; div result to r0 -> not enqueued, fifo_count unchanged.
- **Full FIFO:** 4 accepts with the pipe busy every cycle -> div_ready = 0, fifo_count = 4; one pipe-idle cycle -> one pop, div_ready = 1 the next cycle.
- **Squash and pend_hit:** FIFO holds r9 = 0xAA, rd_addr1 = 9 -> pend_hit1 = 1; pipe writes r9 = 0xBB -> entry squashed, pend_hit1 = 0 the next cycle, and r9 is never overwritten with 0xAA.
- **Starvation:** STARVE_LIMIT=8, pipe busy continuously with a valid head -> stall_req = 1 after 8 cycles; pipe idles -> head granted, stall_req = 0 one cycle later.
